// File: rtl/axis_width_down.sv
// axis_width_down
//   Registered AXI-Stream width downconverter. Each accepted S_BUS_W-wide beat
//   is held in a one-beat buffer and replayed as R = S_BUS_W/M_BUS_W narrow
//   chunks, low chunk first. Chunks above the highest chunk that has any keep
//   bit set are skipped, and m_last rides on the final emitted chunk.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
//   high. Once m_valid is raised it stays high, with m_data/m_keep/m_last
//   stable, until m_ready is seen high. s_* inputs are sampled only on a
//   transfer.
//
// Ports
//   clk, rstn         clock, synchronous active-low reset
//   s_valid/s_ready   wide input handshake
//   s_last/s_keep/s_data   wide beat (word 0 in LSBs, one keep bit per word)
//   m_valid/m_ready   narrow output handshake
//   m_last/m_keep/m_data   narrow chunk
//   dbg_state         current FSM state (ST_EMPTY / ST_BUSY)
module axis_width_down #(
  parameter int WORD_W  = 8,
  parameter int S_BUS_W = 32,
  parameter int M_BUS_W = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          s_last,
  input  logic [S_BUS_W/WORD_W-1:0]     s_keep,
  input  logic [S_BUS_W-1:0]            s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last,
  output logic [M_BUS_W/WORD_W-1:0]     m_keep,
  output logic [M_BUS_W-1:0]            m_data,
  output logic [0:0]                    dbg_state
);

  localparam int S_WPB = S_BUS_W / WORD_W;
  localparam int M_WPB = M_BUS_W / WORD_W;
  localparam int R     = S_BUS_W / M_BUS_W;
  localparam int IDX_W = (R > 1) ? $clog2(R) : 1;

  // The FSM state is exactly the buffer-occupied flag.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_BUSY  = 1'b1;

  logic [S_BUS_W-1:0] buf_data_q,  buf_data_d;
  logic [S_WPB-1:0]   buf_keep_q,  buf_keep_d;
  logic               buf_last_q,  buf_last_d;
  logic [0:0]         buf_valid_q, buf_valid_d;
  logic [IDX_W-1:0]   idx_q,       idx_d;

  logic [IDX_W-1:0]   final_idx;
  logic               at_final;
  logic               s_hs;
  logic               m_hs;

  // Highest chunk whose keep slice is nonzero; 0 for an all-zero keep so a
  // keep-less beat still produces one chunk carrying its last flag.
  always_comb begin
    final_idx = '0;
    for (int k = 0; k < R; k++) begin
      if (buf_keep_q[k*M_WPB +: M_WPB] != '0) final_idx = IDX_W'(k);
    end
  end

  assign at_final = (idx_q == final_idx);

  // Chunk mux for the current index.
  always_comb begin
    m_data = '0;
    m_keep = '0;
    for (int k = 0; k < R; k++) begin
      if (idx_q == IDX_W'(k)) begin
        m_data = buf_data_q[k*M_BUS_W +: M_BUS_W];
        m_keep = buf_keep_q[k*M_WPB +: M_WPB];
      end
    end
  end

  assign m_valid   = buf_valid_q[0];
  assign m_last    = buf_last_q & at_final;
  assign dbg_state = buf_valid_q;

  // Combinational through m_ready so a new beat can load in the same cycle
  // the final chunk of the previous one leaves: no bubble between beats.
  assign s_ready = rstn & ((buf_valid_q == ST_EMPTY) | (m_ready & at_final));

  assign s_hs = s_valid & s_ready;
  assign m_hs = m_valid & m_ready;

  always_comb begin
    buf_data_d  = buf_data_q;
    buf_keep_d  = buf_keep_q;
    buf_last_d  = buf_last_q;
    buf_valid_d = buf_valid_q;
    idx_d       = idx_q;
    if (s_hs) begin
      // Covers both the EMPTY load and the reload on the final chunk.
      buf_data_d  = s_data;
      buf_keep_d  = s_keep;
      buf_last_d  = s_last;
      buf_valid_d = ST_BUSY;
      idx_d       = '0;
    end else if (m_hs) begin
      if (!at_final) begin
        idx_d = idx_q + IDX_W'(1);
      end else begin
        buf_valid_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      buf_data_q  <= '0;
      buf_keep_q  <= '0;
      buf_last_q  <= 1'b0;
      buf_valid_q <= ST_EMPTY;
      idx_q       <= '0;
    end else begin
      buf_data_q  <= buf_data_d;
      buf_keep_q  <= buf_keep_d;
      buf_last_q  <= buf_last_d;
      buf_valid_q <= buf_valid_d;
      idx_q       <= idx_d;
    end
  end

endmodule

// File: tb/tb_axis_width_down.sv
// tb_axis_width_down
//   Bench for axis_width_down with WORD_W=8, S_BUS_W=32, M_BUS_W=8.
//   Expected chunks ({last, keep, data}) are queued when a beat is driven and
//   popped by the output monitor on every m_valid & m_ready transfer.
//   Inputs change 1ns after the rising edge; outputs are sampled on the
//   falling edge.
module tb_axis_width_down;

  localparam int CW = 1 + 1 + 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [3:0]  s_keep;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [0:0]  m_keep;
  logic [7:0]  m_data;
  logic [0:0]  dbg_state;

  logic [CW-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int run_len  = 0;
  int last_run = 0;
  int sready_busy = 0;
  bit rand_mode = 1'b0;

  axis_width_down #(.WORD_W(8), .S_BUS_W(32), .M_BUS_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_keep(s_keep), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .m_keep(m_keep), .m_data(m_data), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- output monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rstn) begin
      if (m_valid) run_len++;
      else begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
      end
      if (m_valid && s_ready) sready_busy++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_chunk", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [CW-1:0] e;
          e = exp_q.pop_front();
          check_eq("m_data", 32'(m_data), 32'(e[7:0]));
          check_eq("m_keep", 32'(m_keep), 32'(e[8]));
          check_eq("m_last", 32'(m_last), 32'(e[9]));
        end
      end
    end
  end

  // Random sink: ready probability ~10%.
  always @(posedge clk) begin
    #1;
    if (rand_mode) m_ready = ($urandom_range(0, 9) == 0);
  end

  // ---------------- driver tasks ----------------
  function automatic logic [CW-1:0] chunk(input logic l, input logic k, input logic [7:0] d);
    return {l, k, d};
  endfunction

  // Called 1ns after a rising edge; returns 1ns after the accepting edge
  // with s_valid still asserted.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("s_hs_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_data  = 'x;
    s_keep  = 'x;
    s_last  = 1'bx;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 20000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_valid) break;
    end
    @(negedge clk);
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn    = 1'b0;
    m_ready = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_keep  = '0;
    s_last  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_s_ready", 32'(s_ready), 32'd0);
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_last",  32'(m_last),  32'd0);
    check_eq("rst_m_keep",  32'(m_keep),  32'd0);
    check_eq("rst_m_data",  32'(m_data),  32'd0);
    check_eq("rst_state",   32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(2);

    // 1: full beat
    exp_q.push_back(chunk(1'b0, 1'b1, 8'h11));
    exp_q.push_back(chunk(1'b0, 1'b1, 8'h22));
    exp_q.push_back(chunk(1'b0, 1'b1, 8'h33));
    exp_q.push_back(chunk(1'b0, 1'b1, 8'h44));
    send_beat(32'h44332211, 4'b1111, 1'b0);
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t1_s_ready_low", 32'(s_ready), 32'd0);
      check_eq("t1_m_valid", 32'(m_valid), 32'd1);
    end
    @(negedge clk);
    check_eq("t1_s_ready_final", 32'(s_ready), 32'd1);
    wait_drain();

    // 2: partial last beat
    exp_q.push_back(chunk(1'b0, 1'b1, 8'hAA));
    exp_q.push_back(chunk(1'b1, 1'b1, 8'hBB));
    send_beat(32'h5A5ABBAA, 4'b0011, 1'b1);
    s_valid = 1'b0;
    @(negedge clk);
    check_eq("t2_last0", 32'(m_last), 32'd0);
    @(negedge clk);
    check_eq("t2_last1", 32'(m_last), 32'd1);
    check_eq("t2_s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    check_eq("t2_done", 32'(m_valid), 32'd0);
    wait_drain();

    // 3: back-to-back throughput
    sready_busy = 0;
    for (int b = 0; b < 3; b++) begin
      logic [31:0] d;
      d = $urandom;
      for (int w = 0; w < 4; w++) begin
        exp_q.push_back(chunk(1'b0, 1'b1, d[w*8 +: 8]));
      end
      send_beat(d, 4'b1111, 1'b0);
    end
    s_valid = 1'b0;
    wait_drain();
    check_eq("t3_run_len", 32'(last_run), 32'd12);
    check_eq("t3_s_ready_pulses", 32'(sready_busy), 32'd3);

    // 4: backpressure on chunk 1
    exp_q.push_back(chunk(1'b0, 1'b1, 8'h11));
    exp_q.push_back(chunk(1'b0, 1'b1, 8'h22));
    exp_q.push_back(chunk(1'b0, 1'b1, 8'h33));
    exp_q.push_back(chunk(1'b0, 1'b1, 8'h44));
    send_beat(32'h44332211, 4'b1111, 1'b0);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t4_hold_data",  32'(m_data),  32'h22);
      check_eq("t4_hold_keep",  32'(m_keep),  32'd1);
      check_eq("t4_hold_last",  32'(m_last),  32'd0);
      check_eq("t4_hold_valid", 32'(m_valid), 32'd1);
      check_eq("t4_s_ready",    32'(s_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_drain();

    // 5: edge keeps
    exp_q.push_back(chunk(1'b1, 1'b0, 8'hC3));
    send_beat(32'h000000C3, 4'b0000, 1'b1);
    s_valid = 1'b0;
    @(negedge clk);
    check_eq("t5_zero_keep_last", 32'(m_last), 32'd1);
    wait_drain();
    exp_q.push_back(chunk(1'b0, 1'b1, 8'h01));
    exp_q.push_back(chunk(1'b0, 1'b0, 8'h02));
    exp_q.push_back(chunk(1'b0, 1'b1, 8'h03));
    send_beat(32'h04030201, 4'b0101, 1'b0);
    s_valid = 1'b0;
    wait_drain();

    // 6: random packets
    rand_mode = 1'b1;
    for (int p = 0; p < 20; p++) begin
      int n;
      n = $urandom_range(1, 100);
      for (int base = 0; base < n; base += 4) begin
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        d = $urandom;
        k = '0;
        l = (base + 4 >= n);
        for (int w = 0; w < 4; w++) begin
          if (base + w < n) begin
            k[w] = 1'b1;
            exp_q.push_back(chunk(base + w == n - 1, 1'b1, d[w*8 +: 8]));
          end
        end
        while ($urandom_range(0, 4) != 0) idle(1);
        send_beat(d, k, l);
      end
      s_valid = 1'b0;
    end
    idle(1);
    wait_drain();
    rand_mode = 1'b0;
    @(posedge clk);
    #1;
    m_ready = 1'b1;

    // Reset mid-packet: only chunk 0 may ever appear.
    exp_q.push_back(chunk(1'b0, 1'b1, 8'h11));
    send_beat(32'h44332211, 4'b1111, 1'b0);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("mid_rst_m_data",  32'(m_data),  32'd0);
    check_eq("mid_rst_m_keep",  32'(m_keep),  32'd0);
    check_eq("mid_rst_m_last",  32'(m_last),  32'd0);
    @(posedge clk);
    #1;
    idle(10);
    check_eq("mid_rst_sb", 32'(exp_q.size()), 32'd0);

    exp_q.push_back(chunk(1'b1, 1'b1, 8'h77));
    send_beat(32'h00000077, 4'b0001, 1'b1);
    s_valid = 1'b0;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
